// File: rtl/psum_burst_tx.sv
// Buffers one burst of psum words, then replays it to the SFU
// as a gap-free valid run followed by a fixed valid-low gap.
module psum_burst_tx #(
  parameter int PSUM_BW_IN = 18,
  parameter int MAX_LEN    = 16,
  parameter int LEN_BW     = 5,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LEN_BW-1:0]     cfg_len,
  input  logic                  cfg_simd,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PSUM_BW_IN-1:0] in_data,
  output logic                  valid_out,
  output logic                  simd_out,
  output logic [PSUM_BW_IN-1:0] psum_out,
  output logic                  burst_done,
  output logic [15:0]           burst_count
);

  localparam int IDX_BW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GAP_BW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {FILL, SEND, GAP} state_t;

  state_t state, state_d;

  logic [PSUM_BW_IN-1:0] mem [MAX_LEN];
  logic [PSUM_BW_IN-1:0] first_word;
  logic [LEN_BW-1:0]     wr_idx, rd_idx, len_q;
  logic [LEN_BW-1:0]     len_in, eff_len;
  logic [GAP_BW-1:0]     gap_cnt;
  logic                  simd_q, simd_in;
  logic                  first, xfer, last_wr, last_rd, gap_end;

  assign in_ready = (state == FILL) && !reset;
  assign xfer     = in_valid && in_ready;
  assign first    = (wr_idx == '0);

  always_comb begin
    len_in = cfg_len;
    if (cfg_len == '0)
      len_in = LEN_BW'(1);
    else if (cfg_len > LEN_BW'(MAX_LEN))
      len_in = LEN_BW'(MAX_LEN);
  end

  // The first word config is live on the bus; later words use the latch.
  assign eff_len    = first ? len_in : len_q;
  assign simd_in    = first ? cfg_simd : simd_q;
  assign first_word = first ? in_data : mem[0];
  assign last_wr    = xfer && (wr_idx == eff_len - LEN_BW'(1));
  assign last_rd    = (rd_idx == len_q);
  assign gap_end    = (gap_cnt == GAP_BW'(GAP_CYCLES - 1));

  always_comb begin
    state_d = state;
    unique case (state)
      FILL:    if (last_wr) state_d = SEND;
      SEND:    if (last_rd) state_d = GAP;
      GAP:     if (gap_end) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (xfer)
      mem[wr_idx[IDX_BW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      wr_idx      <= '0;
      rd_idx      <= '0;
      len_q       <= '0;
      simd_q      <= 1'b0;
      gap_cnt     <= '0;
      valid_out   <= 1'b0;
      simd_out    <= 1'b0;
      psum_out    <= '0;
      burst_done  <= 1'b0;
      burst_count <= '0;
    end else begin
      state      <= state_d;
      burst_done <= 1'b0;
      unique case (state)
        FILL: begin
          if (xfer) begin
            wr_idx <= wr_idx + LEN_BW'(1);
            if (first) begin
              len_q  <= len_in;
              simd_q <= cfg_simd;
            end
          end
          // Present word 0 on the edge that completes the fill.
          if (last_wr) begin
            valid_out <= 1'b1;
            simd_out  <= simd_in;
            psum_out  <= first_word;
            rd_idx    <= LEN_BW'(1);
          end
        end
        SEND: begin
          if (last_rd) begin
            valid_out   <= 1'b0;
            simd_out    <= 1'b0;
            psum_out    <= '0;
            burst_done  <= 1'b1;
            burst_count <= burst_count + 16'd1;
            gap_cnt     <= '0;
          end else begin
            psum_out <= mem[rd_idx[IDX_BW-1:0]];
            rd_idx   <= rd_idx + LEN_BW'(1);
          end
        end
        GAP: begin
          if (gap_end) begin
            wr_idx <= '0;
            rd_idx <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_burst_tx.sv
// Randomized scoreboard bench for psum_burst_tx: driver queues
// expected words/lengths, a negedge monitor checks the SFU side.
module tb_psum_burst_tx;

  localparam int W       = 18;
  localparam int MAX_LEN = 16;
  localparam int LBW     = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic [LBW-1:0] cfg_len;
  logic           cfg_simd;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           valid_out;
  logic           simd_out;
  logic [W-1:0]   psum_out;
  logic           burst_done;
  logic [15:0]    burst_count;

  psum_burst_tx #(
    .PSUM_BW_IN(W), .MAX_LEN(MAX_LEN),
    .LEN_BW(LBW), .GAP_CYCLES(1)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_len(cfg_len), .cfg_simd(cfg_simd),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .valid_out(valid_out), .simd_out(simd_out),
    .psum_out(psum_out),
    .burst_done(burst_done),
    .burst_count(burst_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] psum;
    logic         simd;
  } exp_t;

  exp_t exp_q[$];
  int   len_q[$];
  int   tests = 0;
  int   fails = 0;
  int   model_count = 0;
  int   run = 0;
  bit   prev_valid = 0;
  bit   rst_q = 0;

  function automatic void check(string name, longint act, longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, act, req, $time);
    end
  endfunction

  always @(posedge clk) rst_q <= reset;

  // Monitor: compares the SFU-side stream against the queues.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (rst_q) begin
        check("rst_valid", valid_out, 0);
        check("rst_done", burst_done, 0);
        check("rst_count", burst_count, 0);
        check("rst_ready", in_ready, 0);
      end
      prev_valid = 0;
      run = 0;
    end else begin
      if (valid_out) begin
        check("ready_in_send", in_ready, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("psum_out", psum_out, e.psum);
          check("simd_out", simd_out, e.simd);
        end
        run++;
      end else begin
        check("idle_bus", {simd_out, psum_out}, 0);
        if (prev_valid) begin
          if (len_q.size() == 0) check("no_len", 1, 0);
          else check("run_len", run, len_q.pop_front());
          run = 0;
          model_count++;
          check("done_pulse", burst_done, 1);
          check("count", burst_count, model_count);
          check("ready_in_gap", in_ready, 0);
        end else begin
          check("no_done", burst_done, 0);
        end
      end
      prev_valid = valid_out;
    end
  end

  function automatic int clamp(int l);
    if (l == 0) return 1;
    if (l > MAX_LEN) return MAX_LEN;
    return l;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  // words[] only needs clamp(l) entries; idle_pct sets gap density.
  task automatic send_burst(int l, bit s, logic [W-1:0] words[],
                            int idle_pct);
    int   n = clamp(l);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.psum = words[i];
      e.simd = s;
      exp_q.push_back(e);
    end
    len_q.push_back(n);
    wait_ready();
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < idle_pct) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = words[i];
      cfg_len  = (i == 0) ? LBW'(l) : LBW'($urandom);
      cfg_simd = (i == 0) ? s : 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic rand_burst(int l, int idle_pct);
    logic [W-1:0] w[];
    w = new[MAX_LEN];
    foreach (w[i]) w[i] = W'($urandom);
    send_burst(l, 1'($urandom), w, idle_pct);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || len_q.size() != 0 || valid_out)
           && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check("drain_timeout", exp_q.size() + len_q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] w[];
    reset = 1'b1;
    cfg_len = '0;
    cfg_simd = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", valid_out, 0);
    check("reset_psum", psum_out, 0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);

    w = new[MAX_LEN];
    w[0] = 10; w[1] = 20; w[2] = 30; w[3] = 40;
    send_burst(4, 1'b0, w, 0);
    drain();

    w[0] = 18'h11; w[1] = 18'h22; w[2] = 18'h33;
    send_burst(3, 1'b0, w, 60);
    drain();

    w[0] = {9'd3, 9'd5};
    w[1] = {9'h1FF, 9'd2};
    send_burst(2, 1'b1, w, 0);
    rand_burst(2, 0);
    rand_burst(2, 0);
    drain();

    rand_burst(0, 0);
    rand_burst(20, 10);
    rand_burst(MAX_LEN, 0);
    rand_burst(31, 0);
    drain();

    for (int k = 0; k < 30; k++)
      rand_burst($urandom_range(0, 22), $urandom_range(0, 50));
    drain();

    // Reset two cycles into a 4-word replay.
    rand_burst(4, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_done", burst_done, 0);
    check("mid_rst_count", burst_count, 0);
    exp_q.delete();
    len_q.delete();
    model_count = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("ready_after_mid_rst", in_ready, 1);
    rand_burst(5, 20);
    drain();
    check("final_count", burst_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
